// File: rtl/stack_pointer_unit.sv
// Stack pointer stage: 8-bit SP with push/pop/load and a registered stack address.
// Define STACK_GUARD_EN to build in overflow/underflow protection and write blocking.
module stack_pointer_unit #(
  parameter logic [7:0] SP_RESET = 8'hFF
`ifdef STACK_GUARD_EN
  , parameter logic [7:0] STACK_BASE = 8'hC0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       lsp,
  input  logic       dsp,
  input  logic       isp,
  input  logic [7:0] sp_din,
  output logic [7:0] sp,
  output logic [7:0] mem_addr,
  output logic       mem_addr_vld,
  output logic       wr_block,
  output logic       stk_ovf,
  output logic       stk_unf,
  output logic       ctl_err
);

  logic [7:0] sp_dec;
  logic [7:0] sp_inc;

  assign sp_dec = sp - 8'd1;
  assign sp_inc = sp + 8'd1;

  // Command priority: load beats everything, a push/pop clash issues nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp           <= SP_RESET;
      mem_addr     <= 8'h00;
      mem_addr_vld <= 1'b0;
      ctl_err      <= 1'b0;
`ifdef STACK_GUARD_EN
      wr_block     <= 1'b0;
      stk_ovf      <= 1'b0;
      stk_unf      <= 1'b0;
`endif
    end else if (!stall) begin
      mem_addr_vld <= 1'b0;
      ctl_err      <= 1'b0;
`ifdef STACK_GUARD_EN
      wr_block     <= 1'b0;
`endif
      if (lsp) begin
        sp <= sp_din;
`ifdef STACK_GUARD_EN
        stk_ovf <= 1'b0;
        stk_unf <= 1'b0;
`endif
      end else if (dsp && isp) begin
        ctl_err <= 1'b1;
      end else if (dsp) begin
        mem_addr     <= sp_dec;
        mem_addr_vld <= 1'b1;
`ifdef STACK_GUARD_EN
        if (sp == STACK_BASE) begin
          stk_ovf  <= 1'b1;
          wr_block <= 1'b1;
        end else begin
          sp <= sp_dec;
        end
`else
        sp <= sp_dec;
`endif
      end else if (isp) begin
`ifdef STACK_GUARD_EN
        if (sp == SP_RESET) begin
          stk_unf <= 1'b1;
        end else begin
          mem_addr     <= sp;
          mem_addr_vld <= 1'b1;
          sp           <= sp_inc;
        end
`else
        mem_addr     <= sp;
        mem_addr_vld <= 1'b1;
        sp           <= sp_inc;
`endif
      end
    end
  end

`ifndef STACK_GUARD_EN
  assign wr_block = 1'b0;
  assign stk_ovf  = 1'b0;
  assign stk_unf  = 1'b0;
`endif

endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Stack pointer stage directly downstream of `ControlCodeGenerator4`; consumes its `LSP` and `DSP_out` strobes plus the pipelined ISP strobe from the same control chain. It maintains the 8-bit stack pointer and registers the stack memory address for the memory/write-back stage. It flags stack overflow and underflow, and when the guard is compiled in it blocks the memory write on a faulting push.

## Interface
- `SP_RESET`, 8'hFF: SP value after reset; also the empty-stack value.
- `STACK_BASE`, 8'hC0: lowest legal stack address; used only with the guard.
- `clk` input 1: global clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: pipeline hold; freezes all state when high.
- `lsp` input 1: load SP from `sp_din` (`LSP` from CCG4).
- `dsp` input 1: push, pre-decrement (`DSP_out` from CCG4).
- `isp` input 1: pop, post-increment (pipelined ISP strobe).
- `sp_din` input 8: load value.
- `sp` output 8: current stack pointer.
- `mem_addr` output 8: registered stack address for the memory stage.
- `mem_addr_vld` output 1: `mem_addr` is valid this cycle (push or pop issued last cycle).
- `wr_block` output 1: registered; suppress memory WR for the faulted push.
- `stk_ovf` output 1: sticky overflow.
- `stk_unf` output 1: sticky underflow.
- `ctl_err` output 1: one-cycle pulse; illegal simultaneous `dsp`&`isp`.

## Operation
- Command priority each non-stalled cycle: `lsp` > (`dsp`&`isp`) > `dsp` > `isp` > idle.
- Load: SP <= `sp_din`. Clears `stk_ovf` and `stk_unf`. `mem_addr_vld` <= 0.
- Push: `mem_addr` <= SP-1. SP <= SP-1. `mem_addr_vld` <= 1.
- Pop: `mem_addr` <= SP. SP <= SP+1. `mem_addr_vld` <= 1.
- `dsp`&`isp` together: SP holds. `mem_addr_vld` <= 0. `ctl_err` pulses for 1 cycle.
- Idle: SP holds. `mem_addr_vld` <= 0. `mem_addr` holds its last value.
- Arithmetic is 8-bit modulo 256. No carry out.
- Overflow condition: push with SP == `STACK_BASE`.
- Underflow condition: pop with SP == `SP_RESET`.
- Overflow and underflow handling depends on `STACK_GUARD_EN` (see Configuration).
- `wr_block` is 0 except in the cycle after a faulting push.
- `stall`=1: every register holds, including `mem_addr_vld`, and no `ctl_err` pulse is generated. Inputs are ignored.

## Timing
- Reset values: `sp`=`SP_RESET`, `mem_addr`=8'h00, `mem_addr_vld`=0, `wr_block`=0, `stk_ovf`=0, `stk_unf`=0, `ctl_err`=0.
- Reset is asynchronous. Asserting `rst_n` mid-push or mid-pop discards the operation immediately.
- Latency: a command sampled at edge N appears on `sp`, `mem_addr`, `mem_addr_vld`, `wr_block`, `ctl_err` and the sticky flags after edge N, i.e. throughout cycle N+1.
- Back-to-back commands are allowed every cycle. Each one uses the SP value produced by the previous edge, so push,push from 8'hFF gives addresses 8'hFE, 8'hFD.
- Load and push in the same cycle: load wins; no address is issued.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `STACK_GUARD_EN` defined:
  - Faulting push: SP holds, `stk_ovf` <= 1, `wr_block` <= 1 for one cycle, `mem_addr` <= SP-1, `mem_addr_vld` <= 1.
  - Faulting pop: SP holds, `stk_unf` <= 1, `mem_addr_vld` <= 0.
- `STACK_GUARD_EN` undefined:
  - No guard logic. SP wraps freely (8'h00 push gives 8'hFF, 8'hFF pop gives 8'h00).
  - `stk_ovf`, `stk_unf` and `wr_block` are tied to 0.
  - `STACK_BASE` is unused.

## Test plan
- Reset, then push ×3 → `mem_addr` = 8'hFE, 8'hFD, 8'hFC on consecutive cycles, `mem_addr_vld`=1 each cycle, final `sp`=8'hFC. Then pop ×3 → `mem_addr` = 8'hFC, 8'hFD, 8'hFE, final `sp`=8'hFF.
- `lsp` with `sp_din`=8'h80 asserted together with `dsp` → `sp`=8'h80 next cycle, `mem_addr_vld`=0. Assert `dsp`&`isp` → `sp` holds at 8'h80, `ctl_err` high for exactly 1 cycle.
- Guard enabled: load 8'hC0, then push → `sp` stays 8'hC0, `stk_ovf`=1, `wr_block`=1 for 1 cycle. Then load 8'hF0 → `stk_ovf` clears to 0.
- Guard enabled: from reset, pop → `sp` stays 8'hFF, `stk_unf`=1, `mem_addr_vld`=0.
- Guard disabled: load 8'h00, push → `sp`=8'hFF, `mem_addr`=8'hFF, all flags 0.
- Push with `stall`=1 for 2 cycles, then `stall`=0 → no change during the stall; push completes one cycle after release. Drop `rst_n` asynchronously mid-sequence → all outputs return to reset values before the next edge.
